// File: rtl/reg_arb_pkg.sv
// Shared definitions for the two-port register access arbiter:
// FSM state encoding, requester port indices and the WAIT counter width.
package reg_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_e;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  // Wide enough to hold RD_LATENCY-1 for the largest legal latency of 4.
  localparam int CNT_W = 2;

endpackage

// File: rtl/reg_arb_rr.sv
// Two-way round-robin pick: a lone requester wins, and under contention
// the port that was not granted last time wins.
module reg_arb_rr
  import reg_arb_pkg::*;
(
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_grant_i,
  output logic grant_o,
  output logic valid_o
);

  // Combinational winner selection.
  always_comb begin
    grant_o = PORT0;
    valid_o = req0_i | req1_i;
    if (req0_i && req1_i) begin
      grant_o = (last_grant_i == PORT0) ? PORT1 : PORT0;
    end else if (req1_i) begin
      grant_o = PORT1;
    end
  end

endmodule

// File: rtl/reg_access_arbiter.sv
// Arbitrates two requesters onto a single register bus with a fixed read
// latency, running one transaction at a time through IDLE/ISSUE/WAIT/ACK.
module reg_access_arbiter
  import reg_arb_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_we,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              busy
);

  state_e            state_q, state_d;
  logic              grant_q, grant_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pick_grant;
  logic              pick_valid;

  reg_arb_rr u_rr (
    .req0_i       (req0),
    .req1_i       (req1),
    .last_grant_i (grant_q),
    .grant_o      (pick_grant),
    .valid_o      (pick_valid)
  );

  // State and datapath registers; last grant resets to port 1 so port 0 wins first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      grant_q  <= PORT1;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state logic: latch the winner in IDLE, count read latency in WAIT, capture data on exit.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d = pick_grant;
          we_d    = (pick_grant == PORT1) ? we1 : we0;
          addr_d  = (pick_grant == PORT1) ? addr1 : addr0;
          wdata_d = (pick_grant == PORT1) ? wdata1 : wdata0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = CNT_W'(RD_LATENCY - 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          if (grant_q == PORT1) begin
            rdata1_d = reg_rdata;
          end else begin
            rdata0_d = reg_rdata;
          end
          state_d = ACK;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decode straight from registered state so reset clears them without waiting for a clock.
  always_comb begin
    reg_we    = (state_q == ISSUE) && we_q;
    ack0      = (state_q == ACK) && (grant_q == PORT0);
    ack1      = (state_q == ACK) && (grant_q == PORT1);
    busy      = (state_q != IDLE);
    reg_addr  = addr_q;
    reg_wdata = wdata_q;
    rdata0    = rdata0_q;
    rdata1    = rdata1_q;
  end

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Self-checking bench for reg_access_arbiter: a default-latency instance with a
// register-file model, plus an RD_LATENCY=3 instance fed by a cycle-stamped bus.
module tb_reg_access_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [7:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic       ack0, ack1, reg_we, busy;
  logic [7:0] rdata0, rdata1, reg_addr, reg_wdata, reg_rdata;

  logic       req0_3 = 1'b0, we0_3 = 1'b0, tieLow = 1'b0;
  logic [7:0] addr0_3 = '0, tieZero = '0;
  logic       ack0_3, ack1_3, reg_we3, busy3;
  logic [7:0] rdata0_3, rdata1_3, reg_addr3, reg_wdata3, reg_rdata3;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int weCount = 0;
  int we3Count = 0;
  int ack0Count = 0;
  int ack1Count = 0;
  logic [7:0] weAddr = '0;
  logic [7:0] weData = '0;

  typedef struct {
    bit         port;
    logic [7:0] data;
  } exp_t;
  exp_t sb[$];

  bit [7:0] mem[256];
  bit       written[256];
  logic [7:0] regRdataQ = '0;

  reg_access_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we),
    .reg_rdata(reg_rdata), .busy(busy)
  );

  reg_access_arbiter #(.DATA_W(8), .ADDR_W(8), .RD_LATENCY(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .req0(req0_3), .req1(tieLow), .we0(we0_3), .we1(tieLow),
    .addr0(addr0_3), .addr1(tieZero), .wdata0(tieZero), .wdata1(tieZero),
    .ack0(ack0_3), .ack1(ack1_3), .rdata0(rdata0_3), .rdata1(rdata1_3),
    .reg_addr(reg_addr3), .reg_wdata(reg_wdata3), .reg_we(reg_we3),
    .reg_rdata(reg_rdata3), .busy(busy3)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Cycle counter used to stamp the latency-3 bus data.
  always @(posedge clk) cyc <= cyc + 1;

  // Unwritten registers read back as address+3.
  function automatic logic [7:0] initVal(input logic [7:0] a);
    return a + 8'd3;
  endfunction

  // Register-file model with a one-cycle read pipeline.
  always @(posedge clk) begin
    regRdataQ <= written[reg_addr] ? mem[reg_addr] : initVal(reg_addr);
    if (reg_we) begin
      mem[reg_addr]     <= reg_wdata;
      written[reg_addr] <= 1'b1;
    end
  end
  assign reg_rdata = regRdataQ;

  // Latency-3 bus returns a value derived from the current cycle number.
  assign reg_rdata3 = 8'(cyc * 7 + 3);

  // Monitor counting write strobes and ack pulses.
  always @(negedge clk) begin
    if (reg_we === 1'b1) begin
      weCount++;
      weAddr = reg_addr;
      weData = reg_wdata;
    end
    if (reg_we3 === 1'b1) we3Count++;
    if (ack0 === 1'b1) ack0Count++;
    if (ack1 === 1'b1) ack1Count++;
  end

  // Bounded wait for an ack; lat is the negedge index (0 = request cycle) or -1 on timeout.
  task automatic waitAck(input bit port, input int limit, output int lat);
    lat = -1;
    for (int k = 0; k <= limit; k++) begin
      @(negedge clk);
      if ((port ? ack1 : ack0) === 1'b1) begin
        lat = k;
        return;
      end
    end
  endtask

  task automatic applyStimulus(input bit port, input bit we, input logic [7:0] a, input logic [7:0] d);
    if (port) begin
      we1 = we; addr1 = a; wdata1 = d; req1 = 1'b1;
    end else begin
      we0 = we; addr0 = a; wdata0 = d; req0 = 1'b1;
    end
  endtask

  task automatic doReset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; req0_3 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ack0 !== 1'b0 || ack1 !== 1'b0) begin failures++; $display("[TB] FAIL reset_ack: got %b%b expected 00", ack0, ack1); end
    checks++; if (reg_we !== 1'b0) begin failures++; $display("[TB] FAIL reset_reg_we: got %b expected 0", reg_we); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (rdata0 !== 8'h00 || rdata1 !== 8'h00) begin failures++; $display("[TB] FAIL reset_rdata: got %h/%h expected 00/00", rdata0, rdata1); end
    checks++; if (reg_addr !== 8'h00 || reg_wdata !== 8'h00) begin failures++; $display("[TB] FAIL reset_bus: got %h/%h expected 00/00", reg_addr, reg_wdata); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_read();
    int lat;
    int weBase;
    exp_t e;
    weBase = weCount;
    sb.push_back('{1'b0, 8'h01});
    applyStimulus(1'b0, 1'b0, 8'hFE, 8'h00);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL read_busy_idle: got %b expected 0", busy); end
    @(negedge clk);
    checks++; if (busy !== 1'b1 || reg_addr !== 8'hFE) begin failures++; $display("[TB] FAIL read_issue: busy=%b addr=%h expected 1/fe", busy, reg_addr); end
    waitAck(1'b0, 8, lat);
    req0 = 1'b0;
    lat = (lat < 0) ? -1 : lat + 2;
    checks++; if (lat !== 3) begin failures++; $display("[TB] FAIL read_latency: got %0d expected 3", lat); end
    e = sb.pop_front();
    checks++; if (rdata0 !== e.data) begin failures++; $display("[TB] FAIL read_rdata0: got %h expected %h", rdata0, e.data); end
    checks++; if (weCount !== weBase) begin failures++; $display("[TB] FAIL read_no_we: got %0d strobes expected 0", weCount - weBase); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (rdata0 !== 8'h01) begin failures++; $display("[TB] FAIL read_rdata0_hold: got %h expected 01", rdata0); end
  endtask

  task automatic test_write_read();
    int lat;
    int weBase;
    exp_t e;
    weBase = weCount;
    sb.push_back('{1'b1, 8'h02});
    applyStimulus(1'b1, 1'b1, 8'hFF, 8'hA5);
    waitAck(1'b1, 8, lat);
    req1 = 1'b0;
    checks++; if (lat !== 3) begin failures++; $display("[TB] FAIL write_latency: got %0d expected 3", lat); end
    checks++; if (weCount !== weBase + 1) begin failures++; $display("[TB] FAIL write_we_pulses: got %0d expected 1", weCount - weBase); end
    checks++; if (weAddr !== 8'hFF || weData !== 8'hA5) begin failures++; $display("[TB] FAIL write_bus: got %h/%h expected ff/a5", weAddr, weData); end
    e = sb.pop_front();
    checks++; if (rdata1 !== e.data) begin failures++; $display("[TB] FAIL write_rdata1: got %h expected %h", rdata1, e.data); end
    @(posedge clk); #1;
    weBase = weCount;
    sb.push_back('{1'b1, 8'hA5});
    applyStimulus(1'b1, 1'b0, 8'hFF, 8'h00);
    waitAck(1'b1, 8, lat);
    req1 = 1'b0;
    checks++; if (lat !== 3) begin failures++; $display("[TB] FAIL readback_latency: got %0d expected 3", lat); end
    e = sb.pop_front();
    checks++; if (rdata1 !== e.data) begin failures++; $display("[TB] FAIL readback_rdata1: got %h expected %h", rdata1, e.data); end
    checks++; if (weCount !== weBase) begin failures++; $display("[TB] FAIL readback_no_we: got %0d strobes expected 0", weCount - weBase); end
    @(posedge clk); #1;
  endtask

  task automatic test_contention();
    int acks;
    int issued;
    int prevK;
    bit port;
    bit pend0;
    bit pend1;
    exp_t e;
    doReset();
    for (int i = 0; i < 6; i++) sb.push_back('{bit'(i % 2), (i % 2) ? 8'h24 : 8'h23});
    we0 = 1'b0; we1 = 1'b0; addr0 = 8'h20; addr1 = 8'h21;
    req0 = 1'b1; req1 = 1'b1;
    acks = 0; issued = 2; prevK = -1;
    for (int k = 0; k < 40 && acks < 6; k++) begin
      pend0 = 1'b0; pend1 = 1'b0;
      @(negedge clk);
      if (ack0 === 1'b1 || ack1 === 1'b1) begin
        port = (ack1 === 1'b1);
        e = sb.pop_front();
        checks++; if (ack0 === 1'b1 && ack1 === 1'b1) begin failures++; $display("[TB] FAIL contention_dual_ack: got 11 expected one-hot"); end
        checks++; if (port !== e.port) begin failures++; $display("[TB] FAIL contention_order[%0d]: got port %0d expected port %0d", acks, port, e.port); end
        checks++; if ((port ? rdata1 : rdata0) !== e.data) begin failures++; $display("[TB] FAIL contention_rdata[%0d]: got %h expected %h", acks, port ? rdata1 : rdata0, e.data); end
        checks++; if ((prevK < 0 && k != 3) || (prevK >= 0 && k - prevK != 4)) begin failures++; $display("[TB] FAIL contention_spacing[%0d]: got cycle %0d prev %0d", acks, k, prevK); end
        prevK = k;
        acks++;
        if (port) begin req1 = 1'b0; pend1 = 1'b1; end else begin req0 = 1'b0; pend0 = 1'b1; end
      end
      @(posedge clk); #1;
      if (issued < 6 && pend0) begin req0 = 1'b1; issued++; end
      if (issued < 6 && pend1) begin req1 = 1'b1; issued++; end
    end
    checks++; if (acks != 6) begin failures++; $display("[TB] FAIL contention_timeout: got %0d acks expected 6", acks); end
    req0 = 1'b0; req1 = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_op();
    int lat;
    int ackBase;
    exp_t e;
    applyStimulus(1'b0, 1'b1, 8'h40, 8'h77);
    @(negedge clk);
    @(negedge clk);
    checks++; if (reg_we !== 1'b1) begin failures++; $display("[TB] FAIL midop_issue_we: got %b expected 1", reg_we); end
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || ack0 !== 1'b0 || reg_we !== 1'b0) begin failures++; $display("[TB] FAIL midop_ctrl: busy=%b ack0=%b we=%b expected 000", busy, ack0, reg_we); end
    checks++; if (reg_addr !== 8'h00 || reg_wdata !== 8'h00 || rdata0 !== 8'h00) begin failures++; $display("[TB] FAIL midop_data: got %h/%h/%h expected 00/00/00", reg_addr, reg_wdata, rdata0); end
    req0 = 1'b0; we0 = 1'b0;
    ackBase = ack0Count + ack1Count;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (ack0Count + ack1Count !== ackBase) begin failures++; $display("[TB] FAIL midop_no_ack: got %0d acks expected 0", ack0Count + ack1Count - ackBase); end
    sb.push_back('{1'b1, 8'h77});
    applyStimulus(1'b1, 1'b0, 8'h40, 8'h00);
    waitAck(1'b1, 8, lat);
    req1 = 1'b0;
    e = sb.pop_front();
    checks++; if (lat !== 3 || rdata1 !== e.data) begin failures++; $display("[TB] FAIL midop_recover: lat=%0d rdata1=%h expected 3/%h", lat, rdata1, e.data); end
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b1, 8'h50, 8'h99);
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++; if (reg_we !== 1'b0) begin failures++; $display("[TB] FAIL issue_reset_we: got %b expected 0", reg_we); end
    req0 = 1'b0; we0 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    sb.push_back('{1'b1, 8'h53});
    applyStimulus(1'b1, 1'b0, 8'h50, 8'h00);
    waitAck(1'b1, 8, lat);
    req1 = 1'b0;
    e = sb.pop_front();
    checks++; if (lat !== 3 || rdata1 !== e.data) begin failures++; $display("[TB] FAIL issue_reset_nowrite: lat=%0d rdata1=%h expected 3/%h", lat, rdata1, e.data); end
    @(posedge clk); #1;
  endtask

  task automatic test_input_churn();
    int lat;
    int ackBase;
    exp_t e;
    applyStimulus(1'b1, 1'b1, 8'hFD, 8'h5E);
    waitAck(1'b1, 8, lat);
    req1 = 1'b0; we1 = 1'b0;
    @(posedge clk); #1;
    ackBase = ack0Count;
    sb.push_back('{1'b0, 8'h5E});
    applyStimulus(1'b0, 1'b0, 8'hFD, 8'h00);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    addr0 = 8'h10; we0 = 1'b1; wdata0 = 8'hEE; req0 = 1'b0;
    #1;
    checks++; if (reg_addr !== 8'hFD) begin failures++; $display("[TB] FAIL churn_addr_hold: got %h expected fd", reg_addr); end
    waitAck(1'b0, 4, lat);
    checks++; if (lat !== 0) begin failures++; $display("[TB] FAIL churn_ack_timing: got %0d expected 0", lat); end
    e = sb.pop_front();
    checks++; if (rdata0 !== e.data) begin failures++; $display("[TB] FAIL churn_rdata0: got %h expected %h", rdata0, e.data); end
    repeat (6) @(posedge clk);
    #1;
    checks++; if (ack0Count - ackBase !== 1) begin failures++; $display("[TB] FAIL churn_single_ack: got %0d expected 1", ack0Count - ackBase); end
    we0 = 1'b0;
  endtask

  task automatic test_latency3();
    int lat;
    int holdCount;
    int cIssue;
    int weBase;
    logic [7:0] expData;
    lat = -1; holdCount = 0; cIssue = 0;
    weBase = we3Count;
    we0_3 = 1'b0; addr0_3 = 8'hFC; req0_3 = 1'b1;
    for (int k = 0; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) cIssue = cyc;
      if (k >= 1 && k <= 4 && reg_addr3 === 8'hFC) holdCount++;
      if (ack0_3 === 1'b1) begin
        lat = k;
        break;
      end
    end
    req0_3 = 1'b0;
    expData = 8'((cIssue + 3) * 7 + 3);
    checks++; if (lat !== 5) begin failures++; $display("[TB] FAIL lat3_latency: got %0d expected 5", lat); end
    checks++; if (holdCount !== 4) begin failures++; $display("[TB] FAIL lat3_addr_hold: got %0d cycles expected 4", holdCount); end
    checks++; if (rdata0_3 !== expData) begin failures++; $display("[TB] FAIL lat3_rdata: got %h expected %h", rdata0_3, expData); end
    checks++; if (we3Count !== weBase) begin failures++; $display("[TB] FAIL lat3_no_we: got %0d strobes expected 0", we3Count - weBase); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_read();
    test_contention();
    test_reset_mid_op();
    test_input_churn();
    test_latency3();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/reg_access_arbiter.md
REG_ACCESS_ARBITER -- requirements
Module: reg_access_arbiter

Interface
REQ-001 Parameter DATA_W, default 8: data width of register bus and requester ports.
REQ-002 Parameter ADDR_W, default 8: address width of register bus and requester ports.
REQ-003 Parameter RD_LATENCY, default 1: cycles from register-bus address to valid reg_rdata; legal range 1..4.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 req0 / req1  in  1  access request, level, held until matching ack.
REQ-007 we0 / we1  in  1  1 = write, 0 = read; stable while req high.
REQ-008 addr0 / addr1  in  ADDR_W  register address; stable while req high.
REQ-009 wdata0 / wdata1  in  DATA_W  write data; stable while req high.
REQ-010 ack0 / ack1  out  1  one-cycle completion pulse.
REQ-011 rdata0 / rdata1  out  DATA_W  read data, valid in ack cycle, held until next ack to same port.
REQ-012 reg_addr  out  ADDR_W  register-bus address.
REQ-013 reg_wdata  out  DATA_W  register-bus write data.
REQ-014 reg_we  out  1  register-bus write strobe.
REQ-015 reg_rdata  in  DATA_W  register-bus read data, RD_LATENCY cycles after reg_addr.
REQ-016 busy  out  1  high in every state except IDLE.

Function
REQ-017 FSM states IDLE, ISSUE, WAIT, ACK; one transaction in flight at a time.
REQ-018 IDLE: if any req high, select winner, latch its addr/we/wdata, record grant, go ISSUE; else stay.
REQ-019 Selection: single requester wins; both high -> port not granted last wins (round-robin); first contention after reset -> port 0.
REQ-020 ISSUE (exactly 1 cycle): reg_addr/reg_wdata = latched values; reg_we = latched we; go WAIT.
REQ-021 WAIT: lasts RD_LATENCY cycles (down-counter); reg_addr held, reg_we = 0; at exit edge capture reg_rdata into winner's rdata register (reads and writes alike).
REQ-022 ACK (exactly 1 cycle): winner's ack = 1, other ack = 0; go IDLE.
REQ-023 Latency: req sampled in IDLE at cycle N -> ack in cycle N+2+RD_LATENCY; with default, N+3.
REQ-024 reg_we high for exactly one cycle per write, never for reads; never high outside ISSUE.
REQ-025 Requester shall drop req in cycle after ack; req still high then is treated as a new request.
REQ-026 req dropped mid-transaction: transaction still completes and ack still pulses.
REQ-027 Changes on addr/we/wdata after IDLE latch have no effect on the in-flight transaction.
REQ-028 Losing requester waits with req high; served immediately after winner's ACK.
REQ-029 Outside ISSUE/WAIT reg_addr and reg_wdata hold last driven values.

Reset
REQ-030 rst_n low: state IDLE, ack0/ack1/reg_we/busy = 0, rdata0/rdata1/reg_addr/reg_wdata = 0, last-grant = port 1 (port 0 priority), WAIT counter = 0.
REQ-031 Reset mid-transaction aborts it: no ack issued; reg_we deasserts asynchronously.

Structure
REQ-032 Package reg_arb_pkg holds FSM state encoding and the port-index constants (PORT0, PORT1).
REQ-033 One sub-module, reg_arb_rr: 2-way round-robin pick (req0, req1, last_grant -> grant index, valid); everything else inline.

Verification
REQ-034 Single read: req0, we0=0, addr0=0xFE, reg file returns 0x01 -> reg_we never high, ack0 at N+3, rdata0=0x01.
REQ-035 Write-then-read: req1 write 0xA5 to 0xFF, then read 0xFF -> one reg_we pulse with reg_addr=0xFF/reg_wdata=0xA5; read ack1 with rdata1=0xA5.
REQ-036 Contention: req0 and req1 high in same cycle from reset, both held -> port 0 acked first, port 1 acked 4 cycles later; repeated contention alternates 1,0,1.
REQ-037 Reset mid-op: rst_n low during WAIT of a write -> no ack, all outputs 0 immediately; next request after release completes normally.
REQ-038 RD_LATENCY=3 build: read 0xFC -> reg_addr held 4 cycles, ack at N+5, rdata equals value driven 3 cycles after address.
REQ-039 Input churn: change addr0 from 0xFD to 0x10 during WAIT and drop req0 -> reg_addr stays 0xFD, ack0 still pulses once.
